// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the instruction-register / register
//               select stage: IR field bit positions, field_id encodings,
//               sequencer state codes and the field-walk helper.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // IR field layout
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C_HI   = 18;

  // Source of the current register index
  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_RA   = 2'd1,
    FIELD_RB   = 2'd2,
    FIELD_RC   = 2'd3
  } field_t;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_EMIT_A = 3'd1;
  localparam state_t S_EMIT_B = 3'd2;
  localparam state_t S_EMIT_C = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  // First enabled field at or after position from_pos (0=Ra, 1=Rb, 2=Rc,
  // 3=past the end). mask bit2=Ra, bit1=Rb, bit0=Rc.
  function automatic state_t next_emit(input logic [2:0] mask,
                                       input logic [1:0] from_pos);
    if ((from_pos == 2'd0) && mask[2]) return S_EMIT_A;
    if ((from_pos <= 2'd1) && mask[1]) return S_EMIT_B;
    if ((from_pos <= 2'd2) && mask[0]) return S_EMIT_C;
    return S_DONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_field_extract.sv
`default_nettype none
// ============================================================================
// Module      : ir_field_extract
// Description : Combinational decode of the instruction register into
//               opcode, the three register fields and the sign-extended
//               C constant.
// Ports       : ir      in  DATA_W  instruction register contents
//               opcode  out 5       IR[31:27]
//               ra/rb/rc out 4 each register fields
//               c_sext  out DATA_W  C field sign-extended from bit C_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module ir_field_extract
  import risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int C_W    = 19
) (
  input  logic [DATA_W-1:0] ir,
  output logic [4:0]        opcode,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [3:0]        rc,
  output logic [DATA_W-1:0] c_sext
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign ra     = ir[RA_HI:RA_LO];
  assign rb     = ir[RB_HI:RB_LO];
  assign rc     = ir[RC_HI:RC_LO];
  assign c_sext = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/select_encode_seq.sv
`default_nettype none
// ============================================================================
// Module      : select_encode_seq
// Description : Instruction register plus register-select stage feeding the
//               4-to-16 register decoder. The register index comes either
//               from manual gra/grb/grc strobes or from a sequencer that
//               walks the masked Ra/Rb/Rc fields over valid/ready.
// Ports       : clock, clear          clock / sync active-high reset
//               bus_in, ir_in         IR source and load strobe
//               gra, grb, grc         manual field selects (gra highest)
//               rin, rout, ba_out     qualifiers registered with the index
//               seq_start, seq_mask   start a walk over the masked fields
//               idx_ready             consumer accepts sequenced index
//               reg_index, idx_valid, field_id   registered select output
//               rin_q, rout_q, ba_out_q          registered qualifiers
//               opcode, c_sext        decoded from IR
//               busy, done            sequencer status
// Revision    : 1.0 - initial release
// ============================================================================
module select_encode_seq
  import risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int C_W    = 19
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ir_in,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              ba_out,
  input  logic              seq_start,
  input  logic [2:0]        seq_mask,
  input  logic              idx_ready,
  output logic [3:0]        reg_index,
  output logic              idx_valid,
  output logic [1:0]        field_id,
  output logic              rin_q,
  output logic              rout_q,
  output logic              ba_out_q,
  output logic [4:0]        opcode,
  output logic [DATA_W-1:0] c_sext,
  output logic              busy,
  output logic              done
);

  logic [DATA_W-1:0] ir;
  logic [2:0]        mask_q;
  state_t            state;
  state_t            state_nxt;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic              accept;
  logic              enter_emit;
  logic              nxt_is_emit;
  logic [3:0]        emit_index;
  logic [1:0]        emit_field;
  logic              manual_sel;
  logic [3:0]        manual_index;
  logic [1:0]        manual_field;

  ir_field_extract #(
    .DATA_W (DATA_W),
    .C_W    (C_W)
  ) u_extract (
    .ir     (ir),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .c_sext (c_sext)
  );

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign accept = idx_valid && idx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (seq_start) state_nxt = next_emit(seq_mask, 2'd0);
      S_EMIT_A: if (accept)    state_nxt = next_emit(mask_q, 2'd1);
      S_EMIT_B: if (accept)    state_nxt = next_emit(mask_q, 2'd2);
      S_EMIT_C: if (accept)    state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Field presented by the EMIT state about to be entered.
  always_comb begin
    emit_index  = reg_index;
    emit_field  = field_id;
    nxt_is_emit = 1'b1;
    case (state_nxt)
      S_EMIT_A: begin emit_index = ra; emit_field = FIELD_RA; end
      S_EMIT_B: begin emit_index = rb; emit_field = FIELD_RB; end
      S_EMIT_C: begin emit_index = rc; emit_field = FIELD_RC; end
      default:  nxt_is_emit = 1'b0;
    endcase
  end

  // Entering a new EMIT state is the only time a walk re-samples the
  // index and qualifiers, which keeps them stable across a stall.
  assign enter_emit = nxt_is_emit && (state_nxt != state);

  always_comb begin
    manual_sel   = (state == S_IDLE) && !seq_start && (gra || grb || grc);
    manual_index = rc;
    manual_field = FIELD_RC;
    if (gra) begin
      manual_index = ra;
      manual_field = FIELD_RA;
    end else if (grb) begin
      manual_index = rb;
      manual_field = FIELD_RB;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= S_IDLE;
      ir        <= '0;
      mask_q    <= '0;
      reg_index <= '0;
      field_id  <= FIELD_NONE;
      idx_valid <= 1'b0;
      rin_q     <= 1'b0;
      rout_q    <= 1'b0;
      ba_out_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // IR is frozen once the sequencer leaves IDLE.
      if ((state == S_IDLE) && ir_in) ir <= bus_in;
      if ((state == S_IDLE) && seq_start) mask_q <= seq_mask;

      if (enter_emit) begin
        reg_index <= emit_index;
        field_id  <= emit_field;
        idx_valid <= 1'b1;
        rin_q     <= rin;
        rout_q    <= rout;
        ba_out_q  <= ba_out;
      end else if (manual_sel) begin
        reg_index <= manual_index;
        field_id  <= manual_field;
        idx_valid <= 1'b1;
        rin_q     <= rin;
        rout_q    <= rout;
        ba_out_q  <= ba_out;
      end else if (!nxt_is_emit) begin
        idx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_select_encode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_select_encode_seq
// Description : Scoreboard bench for select_encode_seq. Drivers push the
//               expected index/qualifier/done events into a queue computed
//               from the IR field rules; a negedge monitor pops and compares
//               whenever the DUT presents an index or a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_select_encode_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic        ir_in, gra, grb, grc, rin, rout, ba_out;
  logic        seq_start, idx_ready;
  logic [2:0]  seq_mask;
  logic [3:0]  reg_index;
  logic        idx_valid, rin_q, rout_q, ba_out_q, busy, done;
  logic [1:0]  field_id;
  logic [4:0]  opcode;
  logic [31:0] c_sext;

  select_encode_seq #(.DATA_W(32), .C_W(19)) dut (
    .clock(clock), .clear(clear), .bus_in(bus_in), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .seq_start(seq_start), .seq_mask(seq_mask), .idx_ready(idx_ready),
    .reg_index(reg_index), .idx_valid(idx_valid), .field_id(field_id),
    .rin_q(rin_q), .rout_q(rout_q), .ba_out_q(ba_out_q),
    .opcode(opcode), .c_sext(c_sext), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_done;
    logic [3:0] idx;
    logic [1:0] fid;
    logic [2:0] q;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ir_m = 32'h0;
  logic [3:0]  last_idx = 4'h0;

  // Reference decode: k=0 Ra, 1 Rb, 2 Rc
  function automatic logic [3:0] fld(input logic [31:0] ir, input int k);
    return 4'((ir >> (23 - 4 * k)) & 32'hF);
  endfunction

  function automatic logic [31:0] sext_m(input logic [31:0] ir);
    logic [31:0] c;
    c = ir & 32'h7FFFF;
    if (c >= 32'h40000) c = c - 32'h80000;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clock) begin
    if (!clear) begin
      if (done) begin
        chk("done_expected", 32'(done),
            32'((exp_q.size() > 0) && exp_q[0].is_done));
        chk("done_valid_low", 32'(idx_valid), 32'd0);
        if ((exp_q.size() > 0) && exp_q[0].is_done) void'(exp_q.pop_front());
      end else if (idx_valid) begin
        chk("valid_expected", 32'(idx_valid),
            32'((exp_q.size() > 0) && !exp_q[0].is_done));
        if ((exp_q.size() > 0) && !exp_q[0].is_done) begin
          chk("index_field", {26'd0, field_id, reg_index}, {26'd0, exp_q[0].fid, exp_q[0].idx});
          chk("qualifiers", {29'd0, rin_q, rout_q, ba_out_q}, {29'd0, exp_q[0].q});
          if (idx_ready || !busy) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic load_ir(input logic [31:0] v);
    bus_in = v;
    ir_in  = 1'b1;
    tick();
    ir_in  = 1'b0;
    ir_m   = v;
    chk("opcode", 32'(opcode), ir_m >> 27);
    chk("c_sext", c_sext, sext_m(ir_m));
  endtask

  task automatic idle_check();
    tick();
    chk("idle_valid", 32'(idx_valid), 32'd0);
    chk("idle_hold", 32'(reg_index), 32'(last_idx));
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic manual(input logic a, input logic b, input logic c);
    exp_t e;
    int   k;
    logic [2:0] q;
    q = 3'($urandom);
    gra = a; grb = b; grc = c;
    {rin, rout, ba_out} = q;
    if (a | b | c) begin
      k = a ? 0 : (b ? 1 : 2);
      e.is_done = 1'b0; e.idx = fld(ir_m, k); e.fid = 2'(k + 1); e.q = q;
      exp_q.push_back(e);
      last_idx = e.idx;
    end
    tick();
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    {rin, rout, ba_out} = 3'($urandom);
    idle_check();
  endtask

  task automatic walk(input logic [2:0] mask, input int min_st, input int max_st,
                      input bit junk, input bit with_manual);
    exp_t       e;
    logic [2:0] q[3];
    int         ks[$];
    int         st;
    for (int k = 0; k < 3; k++) if (mask[2-k]) ks.push_back(k);
    for (int i = 0; i < 3; i++) q[i] = 3'($urandom);
    for (int i = 0; i < ks.size(); i++) begin
      e.is_done = 1'b0; e.idx = fld(ir_m, ks[i]); e.fid = 2'(ks[i] + 1); e.q = q[i];
      exp_q.push_back(e);
      last_idx = e.idx;
    end
    e.is_done = 1'b1; e.idx = 4'h0; e.fid = 2'd0; e.q = 3'd0;
    exp_q.push_back(e);

    seq_start = 1'b1;
    seq_mask  = mask;
    {rin, rout, ba_out} = q[0];
    if (with_manual) {gra, grb, grc} = 3'($urandom_range(1, 7));
    tick();
    seq_start = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    for (int i = 0; i < ks.size(); i++) begin
      st = $urandom_range(min_st, max_st);
      repeat (st) begin
        idx_ready = 1'b0;
        {rin, rout, ba_out} = 3'($urandom);
        if (junk) begin
          ir_in     = 1'($urandom);
          bus_in    = $urandom;
          seq_start = 1'($urandom);
          {gra, grb, grc} = 3'($urandom);
        end
        tick();
      end
      ir_in = 1'b0; seq_start = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
      idx_ready = 1'b1;
      {rin, rout, ba_out} = (i + 1 < ks.size()) ? q[i+1] : 3'($urandom);
      tick();
    end
    idx_ready = 1'b0;
    chk("busy_in_done", 32'(busy), 32'd1);
    tick();
    chk("busy_after_walk", 32'(busy), 32'd0);
    chk("valid_after_walk", 32'(idx_valid), 32'd0);
    chk("index_after_walk", 32'(reg_index), 32'(last_idx));
    chk("ir_frozen_opcode", 32'(opcode), ir_m >> 27);
    chk("ir_frozen_c", c_sext, sext_m(ir_m));
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic clear_mid_walk();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.is_done = 1'b0; e.idx = fld(ir_m, k); e.fid = 2'(k + 1); e.q = 3'b101;
      exp_q.push_back(e);
    end
    seq_start = 1'b1; seq_mask = 3'b111; {rin, rout, ba_out} = 3'b101;
    tick();
    seq_start = 1'b0; idx_ready = 1'b1;
    tick();                       // Ra accepted, now in EMIT_B
    chk("emit_b_busy", 32'(busy), 32'd1);
    idx_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    ir_m = 32'h0;
    last_idx = 4'h0;
    chk("abort_valid", 32'(idx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_index", 32'(reg_index), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    clear = 1'b1; bus_in = '0; ir_in = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    rin = 1'b0; rout = 1'b0; ba_out = 1'b0; seq_start = 1'b0; seq_mask = 3'd0;
    idx_ready = 1'b0;
    tick();
    tick();
    chk("rst_index", 32'(reg_index), 32'd0);
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    clear = 1'b0;

    load_ir(32'h0A9A0000);
    chk("opcode_t1", 32'(opcode), 32'd1);
    chk("c_sext_t1", c_sext, 32'h00020000);
    manual(1'b1, 1'b0, 1'b1);
    manual(1'b0, 1'b1, 1'b0);
    manual(1'b0, 1'b0, 1'b0);
    walk(3'b111, 0, 0, 1'b0, 1'b0);
    walk(3'b101, 3, 3, 1'b1, 1'b0);
    load_ir(32'h0007FFFF);
    chk("c_sext_neg", c_sext, 32'hFFFFFFFF);
    walk(3'b000, 0, 0, 1'b0, 1'b0);
    walk(3'b010, 0, 1, 1'b0, 1'b1);
    load_ir(32'h0A9A0000);
    clear_mid_walk();
    load_ir($urandom);
    walk(3'b111, 0, 2, 1'b1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: load_ir($urandom);
        1: manual(1'($urandom), 1'($urandom), 1'($urandom));
        2: walk(3'($urandom), 0, 3, 1'b1, 1'($urandom));
        default: idle_check();
      endcase
    end

    tick();
    chk("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
